led_bar_sequencer: RTL

- Sequences the 10-LED bar driver of the Snake VGA game.
- Produces the bar-level code (0..20) and hand flag that the LED driver decodes.
- Tracks food eaten, shows a fill bar during play, and runs a timed marquee while idle.
- Runs a sweep animation on game over, then holds the driver's default pattern until a new game starts.

---
 rtl/led_bar_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/led_bar_sequencer.sv
// led_bar_sequencer: Snake VGA LED bar sequencer (idle marquee, play fill bar, game-over sweep, hold).
module led_bar_sequencer #(
  parameter int TICK_DIV    = 2500000,
  parameter int SWEEP_LOOPS = 3,
  parameter int SCORE_W     = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic               iEat,
  input  logic               iGameOver,
  input  logic               iPause,
  output logic [9:0]         oOutgo,
  output logic               oHand,
  output logic [SCORE_W-1:0] oScore,
  output logic [1:0]         oState,
  output logic               oSweepDone
);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, SWEEP = 2'd2, HOLD = 2'd3} state_t;
  state_t             state, stateNext;
  logic [4:0]         outgo, outgoNext;
  logic [3:0]         bar, barNext;
  logic [3:0]         loopCnt, loopNext;
  logic [TW-1:0]      tickCnt, tickNext;
  logic [SCORE_W-1:0] score, scoreNext;
  logic               hand, handNext, done, doneNext, tick;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      outgo   <= '0;
      bar     <= '0;
      loopCnt <= '0;
      tickCnt <= '0;
      score   <= '0;
      hand    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= stateNext;
      outgo   <= outgoNext;
      bar     <= barNext;
      loopCnt <= loopNext;
      tickCnt <= tickNext;
      score   <= scoreNext;
      hand    <= handNext;
      done    <= doneNext;
    end
  end
  always_comb begin
    tick      = tickCnt == TW'(TICK_DIV - 1);
    stateNext = state;
    outgoNext = outgo;
    barNext   = bar;
    loopNext  = loopCnt;
    scoreNext = score;
    handNext  = 1'b0;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          stateNext = PLAY;
          scoreNext = '0;
          barNext   = '0;
          outgoNext = '0;
        end else if (tick) outgoNext = (outgo == 5'd19) ? 5'd0 : outgo + 5'd1;
      end
      PLAY: begin
        if (iGameOver) begin
          stateNext = SWEEP;
          outgoNext = '0;
          loopNext  = '0;
        end else begin
          handNext = iPause;
          if (iEat && !iPause) begin
            scoreNext = (score == '1) ? score : score + 1'b1;
            barNext   = (bar == 4'd10) ? 4'd1 : bar + 4'd1;
            outgoNext = 5'(barNext);
          end
        end
      end
      SWEEP: begin
        // one loop ends on the tick that wraps 19 back to 0
        if (tick && outgo == 5'd19) begin
          if (loopCnt + 4'd1 == 4'(SWEEP_LOOPS)) begin
            stateNext = HOLD;
            outgoNext = 5'd20;
            doneNext  = 1'b1;
          end else begin
            outgoNext = '0;
            loopNext  = loopCnt + 4'd1;
          end
        end else if (tick) outgoNext = outgo + 5'd1;
      end
      HOLD: begin
        if (iStart && !iGameOver) begin
          stateNext = PLAY;
          scoreNext = '0;
          barNext   = '0;
          outgoNext = '0;
        end else outgoNext = 5'd20;
      end
    endcase
    tickNext = (stateNext != state || tick) ? '0 : tickCnt + TW'(1);
  end
  assign oOutgo     = {5'd0, outgo};
  assign oHand      = hand;
  assign oScore     = score;
  assign oState     = state;
  assign oSweepDone = done;
endmodule
